// File: rtl/alu_mdu_iter_pkg.sv
// Shared types for the execute-stage ALU/MDU: operator encoding, FSM state codes
// and operator classification helpers.
package alu_mdu_iter_pkg;

  // Non-arithmetic ops keep their encodings; M-extension ops are appended after OP_SW.
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LW, OP_SW,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } operator_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_mdu_op(operator_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_div_op(operator_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic a_is_signed(operator_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_is_signed(operator_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/alu_mdu_iter_if.sv
// Issue-side request bus and result bus of the execute unit.
interface alu_mdu_iter_if
  import alu_mdu_iter_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  operator_e       op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      rd_addr;
  logic            fwd_en;
  logic            invalidate;
  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic [4:0]      res_rd_addr;
  logic            res_fwd_en;
  logic            busy;

  modport master (
    output valid, op, operand_a, operand_b, rd_addr, fwd_en, invalidate,
    input  ready, res_valid, res_data, res_rd_addr, res_fwd_en, busy
  );

  modport slave (
    input  valid, op, operand_a, operand_b, rd_addr, fwd_en, invalidate,
    output ready, res_valid, res_data, res_rd_addr, res_fwd_en, busy
  );
endinterface

// File: rtl/alu_mdu_iter_mdu.sv
// Iterative RV32M datapath: shift-add multiply / restoring divide on magnitudes,
// one bit per cycle, sign fix-up applied to the final step's combinational result.
module alu_mdu_iter_mdu
  import alu_mdu_iter_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  operator_e       op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN);

  logic              run, neg_q, rneg_q, bz_q;
  logic [CNT_W-1:0]  cnt;
  operator_e         op_q;
  logic [XLEN-1:0]   m;
  // mul: {partial high, multiplier}; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc, acc_nx, mul_nx, div_nx, prod;
  logic              a_sgn, b_sgn, qbit;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
  logic [XLEN:0]     msum, shifted;
  logic [XLEN+1:0]   diff;

  assign a_sgn = a_is_signed(op) & a[XLEN-1];
  assign b_sgn = b_is_signed(op) & b[XLEN-1];
  assign a_mag = a_sgn ? -a : a;
  assign b_mag = b_sgn ? -b : b;

  assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
  assign mul_nx  = {msum, acc[XLEN-1:1]};
  assign shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff    = {1'b0, shifted} - {2'b00, m};
  assign qbit    = ~diff[XLEN+1];
  assign div_nx  = {(qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0]), acc[XLEN-2:0], qbit};
  assign acc_nx  = is_div_op(op_q) ? div_nx : mul_nx;

  assign done = run & (cnt == CNT_W'(XLEN - 1));

  // Divide-by-zero leaves |a| in the remainder naturally; only the quotient needs forcing.
  assign prod = neg_q ? -acc_nx : acc_nx;
  assign quo  = bz_q ? '1 : (neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0]);
  assign rem  = rneg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:                        result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result = quo;
      OP_REM, OP_REMU:               result = rem;
      default:                       result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      op_q   <= op;
      neg_q  <= a_sgn ^ b_sgn;
      rneg_q <= a_sgn;
      bz_q   <= (b == '0);
      acc    <= is_div_op(op) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
      m      <= is_div_op(op) ? b_mag : a_mag;
    end else if (run) begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mdu_iter.sv
// Execute stage: single-cycle ALU plus iterative MUL/DIV, registered result,
// valid/ready input handshake and pipeline flush.
module alu_mdu_iter
  import alu_mdu_iter_pkg::*;
#(
  parameter  int XLEN    = 32,
  localparam int SHAMT_W = $clog2(XLEN)
)(
  input  logic          i_clk,
  input  logic          i_rst,
  alu_mdu_iter_if.slave bus
);
  logic [1:0]         state;
  logic               accept, is_mdu, mdu_done, ready;
  logic [XLEN-1:0]    alu_res, mdu_res, out_data;
  logic [SHAMT_W-1:0] shamt;
  logic [4:0]         rd_q, out_rd;
  logic               fwd_q, out_valid, out_fwd;

  assign ready           = (state != ST_CALC);
  assign bus.ready       = ready;
  assign bus.busy        = (state == ST_CALC);
  assign bus.res_valid   = out_valid;
  assign bus.res_data    = out_data;
  assign bus.res_rd_addr = out_rd;
  assign bus.res_fwd_en  = out_fwd;

  assign is_mdu = is_mdu_op(bus.op);
  assign accept = bus.valid & ready & ~bus.invalidate;
  assign shamt  = bus.operand_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = bus.operand_a + bus.operand_b;
    case (bus.op)
      OP_SUB:  alu_res = bus.operand_a - bus.operand_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.operand_a) < $signed(bus.operand_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.operand_a < bus.operand_b};
      OP_XOR:  alu_res = bus.operand_a ^ bus.operand_b;
      OP_OR:   alu_res = bus.operand_a | bus.operand_b;
      OP_AND:  alu_res = bus.operand_a & bus.operand_b;
      OP_SLL:  alu_res = bus.operand_a << shamt;
      OP_SRL:  alu_res = bus.operand_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.operand_a) >>> shamt);
      default: alu_res = bus.operand_a + bus.operand_b;
    endcase
  end

  alu_mdu_iter_mdu #(.XLEN(XLEN)) u_mdu (
    .clk    (i_clk),
    .rst    (i_rst),
    .start  (accept & is_mdu),
    .kill   (bus.invalidate),
    .op     (bus.op),
    .a      (bus.operand_a),
    .b      (bus.operand_b),
    .done   (mdu_done),
    .result (mdu_res)
  );

  // A result already presented in DONE is committed; invalidate only clears what follows.
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.invalidate) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_fwd   <= 1'b0;
      if (i_rst) begin
        rd_q  <= '0;
        fwd_q <= 1'b0;
      end
    end else if (state == ST_CALC) begin
      state     <= mdu_done ? ST_DONE : ST_CALC;
      out_valid <= mdu_done;
      out_data  <= mdu_done ? mdu_res : '0;
      out_rd    <= mdu_done ? rd_q : '0;
      out_fwd   <= mdu_done & fwd_q;
    end else if (accept && !is_mdu) begin
      state     <= ST_IDLE;
      out_valid <= 1'b1;
      out_data  <= alu_res;
      out_rd    <= bus.rd_addr;
      out_fwd   <= bus.fwd_en;
    end else begin
      state     <= accept ? ST_CALC : ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_fwd   <= 1'b0;
      if (accept) begin
        rd_q  <= bus.rd_addr;
        fwd_q <= bus.fwd_en;
      end
    end
  end
endmodule
